// File: rtl/ss_displayer.sv
// Four-digit multiplexed 7-segment scan driver.
// Each slot starts with a dark window; the shadow registers load only at a frame boundary, so a frame never mixes old and new data.
module ss_displayer #(
  parameter int REFRESH_DIV = 25000,
  parameter int BLANK_CYC   = 250,
  parameter int BLINK_DIV   = 62
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg3,
  input  logic [6:0] seg2,
  input  logic [6:0] seg1,
  input  logic [6:0] seg0,
  input  logic [3:0] blank_mask,
  input  logic [3:0] blink_mask,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       frame_tick
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYC);
  localparam logic [FW-1:0] FCNT_LAST = FW'(BLINK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;
  logic [FW-1:0] r_fcnt;
  logic          r_blink_phase;
  logic [6:0]    r_shadow_seg [4];
  logic [3:0]    r_shadow_blank;
  logic [3:0]    r_shadow_blink;

  logic w_frame_end;
  logic w_dark;

  assign w_frame_end = (r_cnt == CNT_LAST) && (r_idx == 2'd3);

  // Dark during the anti-ghosting window, or when the current digit is masked.
  assign w_dark = (r_cnt < CNT_BLANK)
               || r_shadow_blank[r_idx]
               || (r_blink_phase && r_shadow_blink[r_idx]);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt          <= '0;
      r_idx          <= 2'd0;
      r_fcnt         <= '0;
      r_blink_phase  <= 1'b0;
      r_shadow_seg[0] <= seg0;
      r_shadow_seg[1] <= seg1;
      r_shadow_seg[2] <= seg2;
      r_shadow_seg[3] <= seg3;
      r_shadow_blank <= blank_mask;
      r_shadow_blink <= blink_mask;
      an             <= 4'b1111;
      seg            <= 7'b1111111;
      frame_tick     <= 1'b0;
    end else begin
      if (r_cnt == CNT_LAST) begin
        r_cnt <= '0;
        r_idx <= r_idx + 2'd1;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end

      if (w_frame_end) begin
        r_shadow_seg[0] <= seg0;
        r_shadow_seg[1] <= seg1;
        r_shadow_seg[2] <= seg2;
        r_shadow_seg[3] <= seg3;
        r_shadow_blank  <= blank_mask;
        r_shadow_blink  <= blink_mask;
        if (r_fcnt == FCNT_LAST) begin
          r_fcnt        <= '0;
          r_blink_phase <= ~r_blink_phase;
        end else begin
          r_fcnt <= r_fcnt + FW'(1);
        end
      end

      if (w_dark) begin
        an  <= 4'b1111;
        seg <= 7'b1111111;
      end else begin
        an  <= ~(4'b0001 << r_idx);
        seg <= r_shadow_seg[r_idx];
      end
      frame_tick <= w_frame_end;
    end
  end

endmodule
